// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared definitions for the traffic light controller front end:
//   one-hot light encodings, the vehicle debounce state enum and the
//   debounce counter width.
package traffic_pkg;

  // One-hot light codes {R,Y,G}
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  localparam int DEBOUNCE_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL_ON  = 2'd1,
    PRESENT  = 2'd2,
    QUAL_OFF = 2'd3
  } deb_state_e;

endpackage

// File: rtl/sensor_channel.sv
// sensor_channel
//   One vehicle-detector channel: 2-flop synchronizer, debounce FSM and
//   (optionally) a request latch that remembers a car which arrived on red
//   until its direction turns green.
//   Optional feature macro: SENSOR_REQUEST_LATCH_EN (request latch).
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-low reset
//   raw      in  raw asynchronous detector input
//   light    in  own-direction light, one-hot {R,Y,G}
//   present  out debounced vehicle presence (state PRESENT or QUAL_OFF)
//   pending  out registered latched-request flag (0 when latch disabled)
module sensor_channel
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw,
  input  logic [2:0] light,
  output logic       present,
  output logic       pending
);

  localparam logic [DEBOUNCE_CNT_W-1:0] CNT_LIMIT = DEBOUNCE_CNT_W'(DEBOUNCE_CYCLES);

  logic                      sync1_q, sync2_q;
  logic                      sync;
  deb_state_e                state_q, state_d;
  logic [DEBOUNCE_CNT_W-1:0] cnt_q, cnt_d;

  // Synchronizer stage
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  assign sync = sync2_q;

  // Debounce FSM stage
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = QUAL_ON;
          cnt_d   = DEBOUNCE_CNT_W'(1);
        end
      end
      QUAL_ON: begin
        if (!sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d = PRESENT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESENT: begin
        if (!sync) begin
          state_d = QUAL_OFF;
          cnt_d   = DEBOUNCE_CNT_W'(1);
        end
      end
      QUAL_OFF: begin
        if (sync) begin
          state_d = PRESENT;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign present = (state_q == PRESENT) || (state_q == QUAL_OFF);

`ifdef SENSOR_REQUEST_LATCH_EN
  logic pending_q, pending_d;
  logic enter_present;

  assign enter_present = (state_d == PRESENT) && (state_q != PRESENT);

  // Request latch stage: green clears and beats a simultaneous set;
  // yellow and illegal codes match neither compare, so the flag holds.
  always_comb begin
    pending_d = pending_q;
    if (light == LIGHT_GREEN) begin
      pending_d = 1'b0;
    end else if (enter_present && (light == LIGHT_RED)) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;
`else
  logic light_unused;
  assign light_unused = ^light;
  assign pending      = 1'b0;
`endif

endmodule

// File: rtl/vehicle_sensor_conditioner.sv
// vehicle_sensor_conditioner
//   Conditions the two raw vehicle detectors (NS, EW) for the traffic light
//   controller: one sensor_channel per direction plus registered outputs.
//   Optional feature macro: SENSOR_REQUEST_LATCH_EN (latched requests; when
//   undefined, *_pending is 0 and *_sensor follows debounced presence only).
// Ports:
//   clk        in  system clock
//   rst        in  synchronous active-low reset
//   ns_raw     in  raw NS detector (asynchronous)
//   ew_raw     in  raw EW detector (asynchronous)
//   NS_light   in  controller NS light, one-hot {R,Y,G}
//   EW_light   in  controller EW light, one-hot {R,Y,G}
//   NS_sensor  out conditioned NS demand (registered)
//   EW_sensor  out conditioned EW demand (registered)
//   ns_pending out NS latched-request flag
//   ew_pending out EW latched-request flag
module vehicle_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ns_raw,
  input  logic       ew_raw,
  input  logic [2:0] NS_light,
  input  logic [2:0] EW_light,
  output logic       NS_sensor,
  output logic       EW_sensor,
  output logic       ns_pending,
  output logic       ew_pending
);

  logic ns_present, ew_present;
  logic ns_pend, ew_pend;
  logic ns_sensor_q, ns_sensor_d;
  logic ew_sensor_q, ew_sensor_d;

  sensor_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ns (
    .clk     (clk),
    .rst     (rst),
    .raw     (ns_raw),
    .light   (NS_light),
    .present (ns_present),
    .pending (ns_pend)
  );

  sensor_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ew (
    .clk     (clk),
    .rst     (rst),
    .raw     (ew_raw),
    .light   (EW_light),
    .present (ew_present),
    .pending (ew_pend)
  );

  always_comb begin
    ns_sensor_d = ns_present | ns_pend;
    ew_sensor_d = ew_present | ew_pend;
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!rst) begin
      ns_sensor_q <= 1'b0;
      ew_sensor_q <= 1'b0;
    end else begin
      ns_sensor_q <= ns_sensor_d;
      ew_sensor_q <= ew_sensor_d;
    end
  end

  assign NS_sensor  = ns_sensor_q;
  assign EW_sensor  = ew_sensor_q;
  assign ns_pending = ns_pend;
  assign ew_pending = ew_pend;

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// tb_vehicle_sensor_conditioner
//   Directed bench for vehicle_sensor_conditioner at DEBOUNCE_CYCLES=4.
//   Expectations follow SENSOR_REQUEST_LATCH_EN the same way the design does.
module tb_vehicle_sensor_conditioner;
  import traffic_pkg::*;

`ifdef SENSOR_REQUEST_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       ns_raw, ew_raw;
  logic [2:0] NS_light, EW_light;
  logic       NS_sensor, EW_sensor, ns_pending, ew_pending;

  int checks;
  int errors;

  vehicle_sensor_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ns_raw     (ns_raw),
    .ew_raw     (ew_raw),
    .NS_light   (NS_light),
    .EW_light   (EW_light),
    .NS_sensor  (NS_sensor),
    .EW_sensor  (EW_sensor),
    .ns_pending (ns_pending),
    .ew_pending (ew_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    ns_raw   = 1'b1;
    ew_raw   = 1'b1;
    NS_light = LIGHT_YELLOW;
    EW_light = LIGHT_YELLOW;

    // Reset with both detectors active
    repeat (3) tick();
    check("rst_ns_sensor", NS_sensor, 1'b0);
    check("rst_ew_sensor", EW_sensor, 1'b0);
    check("rst_ns_pending", ns_pending, 1'b0);
    check("rst_ew_pending", ew_pending, 1'b0);

    // Release: sensors rise exactly 7 edges after the first sampling edge
    rst = 1'b1;
    repeat (7) tick();
    check("rise_ns_edge6", NS_sensor, 1'b0);
    check("rise_ew_edge6", EW_sensor, 1'b0);
    tick();
    check("rise_ns_edge7", NS_sensor, 1'b1);
    check("rise_ew_edge7", EW_sensor, 1'b1);

    // Deassertion with no pending (yellow lights)
    ns_raw = 1'b0;
    ew_raw = 1'b0;
    repeat (7) tick();
    check("fall_ns_edge6", NS_sensor, 1'b1);
    check("fall_ew_edge6", EW_sensor, 1'b1);
    tick();
    check("fall_ns_edge7", NS_sensor, 1'b0);
    check("fall_ew_edge7", EW_sensor, 1'b0);
    check("fall_ns_pending", ns_pending, 1'b0);

    // Bounce: toggle every 2 cycles on red, nothing may get through
    NS_light = LIGHT_RED;
    for (int i = 0; i < 40; i++) begin
      ns_raw = (((i / 2) % 2) == 0);
      tick();
      check("bounce_ns_sensor", NS_sensor, 1'b0);
      check("bounce_ns_pending", ns_pending, 1'b0);
    end
    repeat (8) tick();
    check("bounce_ns_sensor_after", NS_sensor, 1'b0);
    check("bounce_ns_pending_after", ns_pending, 1'b0);

    // Latched request on EW
    EW_light = LIGHT_RED;
    ew_raw   = 1'b1;
    repeat (10) tick();
    check("latch_ew_pending_set", ew_pending, LATCH);
    ew_raw = 1'b0;
    repeat (7) tick();
    check("latch_ew_sensor_edge6", EW_sensor, 1'b1);
    tick();
    check("latch_ew_sensor_edge7", EW_sensor, LATCH);
    check("latch_ew_pending_edge7", ew_pending, LATCH);
    repeat (5) tick();
    check("latch_ew_sensor_hold", EW_sensor, LATCH);
    check("latch_ew_pending_hold", ew_pending, LATCH);
    check("latch_ns_independent", NS_sensor, 1'b0);
    EW_light = LIGHT_GREEN;
    tick();
    check("green_ew_pending", ew_pending, 1'b0);
    check("green_ew_sensor_lag", EW_sensor, LATCH);
    tick();
    check("green_ew_sensor", EW_sensor, 1'b0);
    check("green_ew_pending2", ew_pending, 1'b0);

    // Set/clear collision on NS: green on the cycle PRESENT is entered
    ns_raw = 1'b1;
    repeat (6) tick();
    NS_light = LIGHT_GREEN;
    tick();
    check("collide_ns_pending", ns_pending, 1'b0);
    NS_light = LIGHT_RED;
    tick();
    check("collide_ns_pending2", ns_pending, 1'b0);
    check("collide_ns_sensor", NS_sensor, 1'b1);
    repeat (3) tick();
    check("collide_ns_pending3", ns_pending, 1'b0);

    // Reset mid-operation with EW pending set
    EW_light = LIGHT_RED;
    ew_raw   = 1'b1;
    repeat (10) tick();
    check("mid_ew_pending_pre", ew_pending, LATCH);
    check("mid_ew_sensor_pre", EW_sensor, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_ew_pending", ew_pending, 1'b0);
    check("mid_ew_sensor", EW_sensor, 1'b0);
    check("mid_ns_sensor", NS_sensor, 1'b0);
    check("mid_ns_pending", ns_pending, 1'b0);
    repeat (7) tick();
    check("mid_ew_requal_edge6", EW_sensor, 1'b0);
    check("mid_ns_requal_edge6", NS_sensor, 1'b0);
    tick();
    check("mid_ew_requal_edge7", EW_sensor, 1'b1);
    check("mid_ns_requal_edge7", NS_sensor, 1'b1);
    check("mid_ew_pending_reset", ew_pending, LATCH);
    check("mid_ns_pending_reset", ns_pending, LATCH);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vehicle_sensor_conditioner.md
# vehicle_sensor_conditioner

Upstream stage of the traffic light controller. Takes the two raw, asynchronous vehicle-detector inputs, synchronizes and debounces each one, and drives the controller's `NS_sensor` / `EW_sensor` inputs. The controller's `NS_light` / `EW_light` outputs come back in so that a car arriving at a red light is remembered until that direction is served green. There are two identical channels, NS and EW.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples needed to accept a level change; legal range 1..15.
- `clk  in  1`: system clock.
- `rst  in  1`: synchronous, active-low reset.
- `ns_raw  in  1`: raw NS detector, asynchronous, may bounce.
- `ew_raw  in  1`: raw EW detector, asynchronous, may bounce.
- `NS_light  in  3`: controller NS light; one-hot {R,Y,G}: 3'b100 red, 3'b010 yellow, 3'b001 green.
- `EW_light  in  3`: controller EW light, same encoding.
- `NS_sensor  out  1`: conditioned NS demand, to the controller.
- `EW_sensor  out  1`: conditioned EW demand, to the controller.
- `ns_pending  out  1`: NS latched-request flag.
- `ew_pending  out  1`: EW latched-request flag.

## Operation
- **Synchronizer.** Per channel, a 2-flop synchronizer on `*_raw` produces `sync`.
- **Debounce FSM.** Per channel, states IDLE, QUAL_ON, PRESENT, QUAL_OFF; counter `cnt`, width 4.
  - IDLE: `sync`=1 → QUAL_ON with `cnt`=1; else stay.
  - QUAL_ON: `sync`=0 → IDLE, `cnt`=0. `sync`=1 and `cnt`==DEBOUNCE_CYCLES → PRESENT. Else `cnt`++.
  - PRESENT: `sync`=0 → QUAL_OFF with `cnt`=1; else stay.
  - QUAL_OFF: `sync`=1 → PRESENT, `cnt`=0. `sync`=0 and `cnt`==DEBOUNCE_CYCLES → IDLE. Else `cnt`++.
  - With DEBOUNCE_CYCLES=1, QUAL_ON/QUAL_OFF last exactly one cycle.
- **present** = state ∈ {PRESENT, QUAL_OFF}.
- **Request latch `pending`.** Set on the cycle the FSM enters PRESENT while the own light == red. Cleared on any cycle the own light == green.
  - Set and clear in the same cycle: clear wins.
  - Yellow neither sets nor clears.
- **Output.** `*_sensor` = present OR pending, registered.
- **Channel independence.** The two channels share no state. Simultaneous arrivals are conditioned independently, with no arbitration (arbitration is the controller's job).
- **Illegal light codes.** Non-one-hot light codes are treated as "not red, not green": pending is held.

## Timing
- **Reset.** While `rst`=0 at a clock edge: sync flops 0, FSM IDLE, `cnt` 0, pending 0, `NS_sensor`/`EW_sensor`/`ns_pending`/`ew_pending` = 0 from the next edge. Reset mid-qualification or with pending set discards everything.
- **Assertion latency.** Raw rising level held stable, first sampled at edge k → `*_sensor` high after edge k+2+DEBOUNCE_CYCLES+1. That is 2 sync + DEBOUNCE_CYCLES qualification + 1 output register, i.e. 7 edges at the default.
- **Deassertion latency.** Same count, provided pending is clear.
- **Glitch rejection.** A raw pulse or bounce shorter than DEBOUNCE_CYCLES synchronized cycles never changes `*_sensor`.
- **Latched requests.** `*_pending` is registered and visible one edge after the set/clear condition. It holds `*_sensor` high after the car leaves, until green.
- **Throughput.** No handshake: the outputs are levels sampled by the controller every cycle.

## Configuration
- Macro `SENSOR_REQUEST_LATCH_EN`.
- **Defined:** pending latch as above.
- **Undefined:** pending logic is removed, `*_pending` is tied 0, and `*_sensor` = present only. Latency is unchanged. The light inputs remain ports but are unused.

## Structure
- **Shared package `traffic_pkg`:**
  - light encoding constants LIGHT_RED/LIGHT_YELLOW/LIGHT_GREEN (3'b100/3'b010/3'b001);
  - debounce state enum (IDLE, QUAL_ON, PRESENT, QUAL_OFF);
  - `DEBOUNCE_CNT_W`=4.
- **Sub-module `sensor_channel`:** one per direction, containing sync + FSM + latch. It is instantiated twice. The top level only wires the channels and registers the outputs.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Reset:** `rst`=0 with `ns_raw`=`ew_raw`=1 → all outputs 0. Release, hold raws high → both sensors rise exactly 7 edges later.
- **Bounce rejection:** `ns_raw` toggles 1/0 every 2 cycles for 40 cycles → `NS_sensor` stays 0, `ns_pending` stays 0.
- **Latched request:** `EW_light`=red, `ew_raw` high 10 cycles then low → `ew_pending`=1 and `EW_sensor` held 1. Set `EW_light`=green → both drop to 0 on the following edges.
- **Set/clear collision:** qualification completes on the exact cycle `NS_light` becomes green → `ns_pending` stays 0.
- **Reset mid-operation:** pending set, `rst` pulsed low 1 cycle → `*_pending` and `*_sensor` = 0, FSM restarts qualification.
- **Macro off:** repeat the latched-request scenario → `EW_sensor` falls 7 edges after `ew_raw` falls, `ew_pending` always 0.
